wrf_rx_frame_buffer: RTL and testbench

Parametrised successor to the single-width mini-NIC packet buffer. It accepts whole frames from a WR fabric (pipelined Wishbone) sink port and stores them in an internal circular buffer of g_depth words. A frame is committed only once it is complete and error-free. Frames that overflow the buffer or carry an error status are rolled back and counted. Stored frames are drained through a first-word-fall-through pull interface, for use between an endpoint and a CPU/NIC DMA.

---
 rtl/wrf_rx_frame_buffer.sv | 202 ++++++++++++++++++++
 tb/tb_wrf_rx_frame_buffer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wrf_rx_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : wrf_rx_frame_buffer
// Purpose  : Receive-side frame buffer. It takes whole frames from a pipelined
//            Wishbone fabric sink and stores them in a circular RAM. A frame
//            becomes visible only after a clean commit. Overflowing or
//            errored frames are rolled back and counted. Stored words drain
//            through a first-word-fall-through pull port.
// Ports    : clk_sys_i/rst_n_i - clock, synchronous active-low reset
//            snk_*             - fabric sink (dat/adr/sel/cyc/stb/we in,
//                                stall/ack/err out)
//            rd_*              - FWFT read port (dat/eof/valid out, req in)
//            frame_cnt_o       - committed, unread frames
//            drop_cnt_o        - dropped frames (wrapping)
//            irq_o             - level, frames pending
// Revision : 1.0 - initial release
// ============================================================================
module wrf_rx_frame_buffer #(
  parameter int g_data_width     = 16,
  parameter int g_depth          = 1024,
  parameter int g_drop_cnt_width = 16
) (
  input  logic                          clk_sys_i,
  input  logic                          rst_n_i,
  input  logic [g_data_width-1:0]       snk_dat_i,
  input  logic [1:0]                    snk_adr_i,
  input  logic [g_data_width/8-1:0]     snk_sel_i,
  input  logic                          snk_cyc_i,
  input  logic                          snk_stb_i,
  input  logic                          snk_we_i,
  output logic                          snk_stall_o,
  output logic                          snk_ack_o,
  output logic                          snk_err_o,
  output logic [g_data_width-1:0]       rd_dat_o,
  output logic                          rd_eof_o,
  output logic                          rd_valid_o,
  input  logic                          rd_req_i,
  output logic [$clog2(g_depth)-1:0]    frame_cnt_o,
  output logic [g_drop_cnt_width-1:0]   drop_cnt_o,
  output logic                          irq_o
);

  localparam int ADDR_W = $clog2(g_depth);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RX     = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [g_data_width:0]   mem [g_depth];
  logic [ADDR_W-1:0]       wptr, wptr_tmp, rptr;
  logic                    ovf, err, wrote, rst_done, cyc_gap;
  logic [g_data_width-1:0] last_dat;

  logic                    beat, start, in_frame, data_beat, stat_beat;
  logic [ADDR_W-1:0]       cur_ptr, ptr_inc, rptr_nxt;
  logic                    cur_ovf, full, data_wr, commit_ok, commit_drop;
  logic                    consume, load, eof_consume;
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_addr;
  logic [g_data_width:0]   mem_wdata;

  // Byte selects carry no meaning here: every byte of a beat is stored.
  logic unused_sel;
  assign unused_sel = ^snk_sel_i;

  assign snk_err_o   = 1'b0;
  // rst_done holds stall high through reset and releases it one clock later.
  assign snk_stall_o = ~rst_done | (state == ST_COMMIT);
  assign irq_o       = (frame_cnt_o != '0);

  // ---------------------------------------------------------------- write side
  assign beat      = snk_cyc_i & snk_stb_i & ~snk_stall_o;
  // A new frame needs cyc to have been seen low since the last start, so a
  // cycle still held high across a reset is not mistaken for a fresh frame.
  assign start     = (state == ST_IDLE) & snk_cyc_i & cyc_gap;
  assign in_frame  = start | (state == ST_RX);
  // The opening beat may arrive in the same clock as cyc rises, so the
  // per-frame state is taken from its initial values on that clock.
  assign cur_ptr   = start ? wptr : wptr_tmp;
  assign cur_ovf   = start ? 1'b0 : ovf;
  assign ptr_inc   = cur_ptr + 1'b1;
  assign full      = (ptr_inc == rptr);
  assign data_beat = beat & in_frame & snk_we_i & (snk_adr_i == 2'd0);
  assign stat_beat = beat & in_frame & snk_we_i & (snk_adr_i == 2'd2);
  assign data_wr   = data_beat & ~cur_ovf & ~full;

  assign commit_ok   = (state == ST_COMMIT) & ~ovf & ~err & wrote;
  assign commit_drop = (state == ST_COMMIT) & (ovf | err);

  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start)      state_nxt = ST_RX;
      ST_RX:     if (!snk_cyc_i) state_nxt = ST_COMMIT;
      ST_COMMIT:                 state_nxt = ST_IDLE;
      default:                   state_nxt = ST_IDLE;
    endcase
  end

  // Data beats and the EOF rewrite of the commit never share a clock
  // (stall is high while committing), so one write port serves both.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = cur_ptr;
    mem_wdata = {1'b0, snk_dat_i};
    if (data_wr) begin
      mem_we = rst_n_i;
    end else if (commit_ok) begin
      mem_we    = rst_n_i;
      mem_addr  = wptr_tmp - 1'b1;
      mem_wdata = {1'b1, last_dat};
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge clk_sys_i) begin
    if (!snk_cyc_i)              cyc_gap <= 1'b1;
    else if (start || !rst_n_i)  cyc_gap <= 1'b0;
  end

  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i) begin
      rst_done    <= 1'b0;
      snk_ack_o   <= 1'b0;
      wptr        <= '0;
      wptr_tmp    <= '0;
      ovf         <= 1'b0;
      err         <= 1'b0;
      wrote       <= 1'b0;
      last_dat    <= '0;
      frame_cnt_o <= '0;
      drop_cnt_o  <= '0;
    end else begin
      rst_done  <= 1'b1;
      snk_ack_o <= beat;
      if (start) begin
        wptr_tmp <= wptr;
        ovf      <= 1'b0;
        err      <= 1'b0;
        wrote    <= 1'b0;
      end
      // Once full, the rest of the frame is acked but not written.
      if (data_beat && !cur_ovf) begin
        if (full) begin
          ovf <= 1'b1;
        end else begin
          wptr_tmp <= ptr_inc;
          last_dat <= snk_dat_i;
          wrote    <= 1'b1;
        end
      end
      if (stat_beat)   err        <= snk_dat_i[1];
      if (commit_ok)   wptr       <= wptr_tmp;
      if (commit_drop) drop_cnt_o <= drop_cnt_o + 1'b1;
      case ({commit_ok, eof_consume})
        2'b10:   frame_cnt_o <= frame_cnt_o + 1'b1;
        2'b01:   frame_cnt_o <= frame_cnt_o - 1'b1;
        default: frame_cnt_o <= frame_cnt_o;
      endcase
    end
  end

  // ----------------------------------------------------------------- read side
  // rptr always addresses the head word; rd_valid_o says it has been fetched.
  // On a consume the following word is fetched in the same clock, so a
  // steadily pulled stream has no bubbles.
  assign consume     = rd_req_i & rd_valid_o;
  assign eof_consume = consume & rd_eof_o;
  assign rptr_nxt    = consume ? rptr + 1'b1 : rptr;
  assign load        = (~rd_valid_o | consume) & (rptr_nxt != wptr);

  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i) begin
      rptr       <= '0;
      rd_valid_o <= 1'b0;
      rd_eof_o   <= 1'b0;
      rd_dat_o   <= '0;
    end else begin
      rptr <= rptr_nxt;
      if (load) begin
        {rd_eof_o, rd_dat_o} <= mem[rptr_nxt];
        rd_valid_o           <= 1'b1;
      end else if (consume) begin
        rd_valid_o <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wrf_rx_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_wrf_rx_frame_buffer
// Purpose  : Self-checking bench. Two instances (depth 1024 and depth 64)
//            share one stimulus bus; 'sel' picks the active one. Expected
//            read words are queued as frames are sent and popped on reads.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wrf_rx_frame_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n  = 1'b0;
  logic        sel    = 1'b0;
  logic        cyc    = 1'b0;
  logic        stb    = 1'b0;
  logic        we     = 1'b1;
  logic        rd_req = 1'b0;
  logic [1:0]  adr    = 2'd0;
  logic [15:0] dat    = 16'h0;
  logic [1:0]  bsel   = 2'b11;

  logic        stall_b, ack_b, err_b, eof_b, valid_b, irq_b;
  logic [15:0] rdat_b, drop_b;
  logic [9:0]  fc_b;
  logic        stall_s, ack_s, err_s, eof_s, valid_s, irq_s;
  logic [15:0] rdat_s, drop_s;
  logic [5:0]  fc_s;

  logic        cyc_b, stb_b, req_b, cyc_s, stb_s, req_s;
  assign cyc_b = cyc & ~sel;
  assign stb_b = stb & ~sel;
  assign req_b = rd_req & ~sel;
  assign cyc_s = cyc & sel;
  assign stb_s = stb & sel;
  assign req_s = rd_req & sel;

  logic        stall, ack, eof, valid, irq;
  logic [15:0] rdat, drop;
  logic [9:0]  fc;
  assign stall = sel ? stall_s : stall_b;
  assign ack   = sel ? ack_s   : ack_b;
  assign eof   = sel ? eof_s   : eof_b;
  assign valid = sel ? valid_s : valid_b;
  assign irq   = sel ? irq_s   : irq_b;
  assign rdat  = sel ? rdat_s  : rdat_b;
  assign drop  = sel ? drop_s  : drop_b;
  assign fc    = sel ? {4'b0, fc_s} : fc_b;

  wrf_rx_frame_buffer #(.g_data_width(16), .g_depth(1024), .g_drop_cnt_width(16)) u_big (
    .clk_sys_i(clk), .rst_n_i(rst_n),
    .snk_dat_i(dat), .snk_adr_i(adr), .snk_sel_i(bsel),
    .snk_cyc_i(cyc_b), .snk_stb_i(stb_b), .snk_we_i(we),
    .snk_stall_o(stall_b), .snk_ack_o(ack_b), .snk_err_o(err_b),
    .rd_dat_o(rdat_b), .rd_eof_o(eof_b), .rd_valid_o(valid_b), .rd_req_i(req_b),
    .frame_cnt_o(fc_b), .drop_cnt_o(drop_b), .irq_o(irq_b)
  );

  wrf_rx_frame_buffer #(.g_data_width(16), .g_depth(64), .g_drop_cnt_width(16)) u_small (
    .clk_sys_i(clk), .rst_n_i(rst_n),
    .snk_dat_i(dat), .snk_adr_i(adr), .snk_sel_i(bsel),
    .snk_cyc_i(cyc_s), .snk_stb_i(stb_s), .snk_we_i(we),
    .snk_stall_o(stall_s), .snk_ack_o(ack_s), .snk_err_o(err_s),
    .rd_dat_o(rdat_s), .rd_eof_o(eof_s), .rd_valid_o(valid_s), .rd_req_i(req_s),
    .frame_cnt_o(fc_s), .drop_cnt_o(drop_s), .irq_o(irq_s)
  );

  int checks   = 0;
  int failures = 0;
  int acks     = 0;
  logic [16:0] q[$];

  always @(negedge clk) if (ack === 1'b1) acks++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag);
    logic [16:0] e;
    chk({tag, "_sb_nonempty"}, q.size() != 0, 1);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk(tag, {eof, rdat}, e);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (stall !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("stall_timeout", stall, 0);
  endtask

  // Sends one frame; returns two clocks after cyc drops (commit visible).
  // rd_tail pulls the head word during the commit cycle.
  task automatic send_frame(input int n_data, input int base, input bit rnd,
                            input bit push, input int n_oob, input bit with_st,
                            input logic [15:0] st, input bit rd_tail);
    logic [15:0] d;
    int a0;
    wait_ready();
    a0  = acks;
    cyc = 1'b1;
    for (int i = 0; i < n_oob; i++) begin
      stb = 1'b1; adr = 2'd1; dat = 16'hAAAA;
      @(negedge clk);
    end
    for (int i = 0; i < n_data; i++) begin
      d   = rnd ? 16'($urandom) : 16'(base + i);
      stb = 1'b1; adr = 2'd0; dat = d;
      if (push) q.push_back({(i == n_data - 1), d});
      @(negedge clk);
    end
    if (with_st) begin
      stb = 1'b1; adr = 2'd2; dat = st;
      @(negedge clk);
    end
    stb = 1'b0; cyc = 1'b0; adr = 2'd0;
    @(negedge clk);
    if (rd_tail) begin
      check_head("tail_word");
      rd_req = 1'b1;
    end
    @(negedge clk);
    rd_req = 1'b0;
    chk("ack_count", acks - a0, n_data + n_oob + (with_st ? 1 : 0));
  endtask

  task automatic read_words(input int n, input int budget, input string tag);
    int got = 0;
    int t   = 0;
    while (got < n && t < budget) begin
      @(negedge clk);
      t++;
      if (valid === 1'b1) begin
        check_head(tag);
        rd_req = 1'b1;
        got++;
      end else begin
        rd_req = 1'b0;
      end
    end
    @(negedge clk);
    rd_req = 1'b0;
    chk({tag, "_count"}, got, n);
  endtask

  int lens[100];
  int total;
  int a_before;

  initial begin
    // ---- reset values
    repeat (3) @(negedge clk);
    chk("rst_stall", stall, 1);
    chk("rst_ack", ack, 0);
    chk("rst_valid", valid, 0);
    chk("rst_eof", eof, 0);
    chk("rst_dat", rdat, 0);
    chk("rst_fc", fc, 0);
    chk("rst_drop", drop, 0);
    chk("rst_irq", irq, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("stall_release", stall, 0);

    // ---- one frame 0..29
    send_frame(30, 0, 0, 1, 0, 0, 16'h0, 0);
    chk("f30_fc", fc, 1);
    chk("f30_irq", irq, 1);
    chk("f30_valid_early", valid, 0);
    @(negedge clk);
    chk("f30_valid_rise", valid, 1);
    read_words(30, 200, "f30_word");
    chk("f30_fc_after", fc, 0);
    chk("f30_valid_after", valid, 0);
    chk("f30_irq_after", irq, 0);

    // ---- rd_req while empty is ignored
    rd_req = 1'b1;
    repeat (3) @(negedge clk);
    rd_req = 1'b0;
    chk("empty_req_valid", valid, 0);
    chk("empty_req_fc", fc, 0);

    // ---- 100 random frames with a concurrent reader
    total = 0;
    for (int i = 0; i < 100; i++) begin
      lens[i] = int'($urandom_range(750, 30));
      total += lens[i];
    end
    fork
      begin
        for (int i = 0; i < 100; i++) send_frame(lens[i], 0, 1, 1, 0, 0, 16'h0, 0);
      end
      read_words(total, total * 3 + 10000, "rand_word");
    join
    chk("rand_drop", drop, 0);
    chk("rand_fc", fc, 0);

    // ---- errored frame dropped, next clean frame kept
    send_frame(10, 16'h500, 0, 0, 0, 1, 16'h0002, 0);
    chk("err_drop", drop, 1);
    chk("err_fc", fc, 0);
    send_frame(12, 16'h600, 0, 1, 0, 0, 16'h0, 0);
    chk("clean_fc", fc, 1);
    read_words(12, 100, "clean_word");

    // ---- OOB-only frame and a strobe outside cyc
    send_frame(0, 0, 0, 0, 3, 0, 16'h0, 0);
    chk("oob_fc", fc, 0);
    chk("oob_drop", drop, 1);
    a_before = acks;
    stb = 1'b1;
    repeat (2) @(negedge clk);
    stb = 1'b0;
    repeat (2) @(negedge clk);
    chk("stray_stb_ack", acks - a_before, 0);

    // ---- commit coincides with EOF consume
    send_frame(4, 16'h40, 0, 1, 0, 0, 16'h0, 0);
    read_words(3, 50, "a_word");
    send_frame(5, 16'h50, 0, 1, 0, 0, 16'h0, 1);
    chk("same_cycle_fc", fc, 1);
    read_words(5, 50, "b_word");
    chk("same_cycle_fc_end", fc, 0);

    // ---- reset mid-frame with two frames stored
    send_frame(5, 16'h700, 0, 1, 0, 0, 16'h0, 0);
    send_frame(6, 16'h710, 0, 1, 0, 0, 16'h0, 0);
    chk("pre_rst_fc", fc, 2);
    wait_ready();
    cyc = 1'b1;
    for (int i = 0; i < 4; i++) begin
      stb = 1'b1; adr = 2'd0; dat = 16'(16'h720 + i);
      @(negedge clk);
    end
    stb = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_stall", stall, 1);
    chk("mid_rst_ack", ack, 0);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_eof", eof, 0);
    chk("mid_rst_dat", rdat, 0);
    chk("mid_rst_fc", fc, 0);
    chk("mid_rst_drop", drop, 0);
    chk("mid_rst_irq", irq, 0);
    rst_n = 1'b1; cyc = 1'b0;
    q.delete();
    repeat (3) @(negedge clk);
    chk("post_rst_fc", fc, 0);
    chk("post_rst_valid", valid, 0);
    send_frame(7, 16'h800, 0, 1, 0, 0, 16'h0, 0);
    chk("post_rst_frame_fc", fc, 1);
    read_words(7, 50, "post_rst_word");
    chk("post_rst_drop", drop, 0);

    // ---- fill the 64-deep instance with no reads
    sel = 1'b1;
    repeat (2) @(negedge clk);
    send_frame(40, 16'h100, 0, 1, 0, 0, 16'h0, 0);
    send_frame(40, 16'h200, 0, 0, 0, 0, 16'h0, 0);
    chk("fill_fc", fc, 1);
    chk("fill_drop", drop, 1);
    read_words(40, 200, "fill_word");
    repeat (2) @(negedge clk);
    chk("fill_valid_end", valid, 0);
    chk("fill_fc_end", fc, 0);
    chk("sb_empty_end", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
